// File: rtl/decrementer_timer_if.sv
// Control/status bundle for decrementer_timer: the requester drives load/enable/abort
// and observes the registered count, busy flag and done pulse.
interface decrementer_timer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start, load_val, en, abort,
    input  count, busy, done
  );

  modport slave (
    input  start, load_val, en, abort,
    output count, busy, done
  );
endinterface

// File: rtl/decrementer_timer.sv
// Loadable WIDTH-bit countdown timer with one-cycle done pulse and optional auto-reload,
// used as the delay/timeout counter for downstream control FSMs.
module decrementer_timer #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  decrementer_timer_if.slave  bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;

  logic             w_load_zero;
  logic             w_last_step;

  // Floor-at-zero decrement: the counter can never wrap from 0 to all-ones.
  function automatic logic [WIDTH-1:0] dec_floor(input logic [WIDTH-1:0] val);
    if (val == '0) begin
      dec_floor = '0;
    end else begin
      dec_floor = val - WIDTH'(1);
    end
  endfunction

  assign w_load_zero = (bus.load_val == '0);
  assign w_last_step = (r_count <= WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        // Abort freezes the count where it stands for post-mortem inspection.
        r_state <= S_IDLE;
      end else if (bus.start) begin
        if (w_load_zero) begin
          r_count <= '0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end else begin
          r_count  <= bus.load_val;
          r_reload <= bus.load_val;
          r_state  <= S_COUNT;
        end
      end else if ((r_state == S_COUNT) && bus.en) begin
        if (w_last_step) begin
          r_done <= 1'b1;
          if (AUTO_RELOAD) begin
            r_count <= r_reload;
          end else begin
            r_count <= '0;
            r_state <= S_IDLE;
          end
        end else begin
          r_count <= dec_floor(r_count);
        end
      end
    end
  end

  assign bus.count = r_count;
  assign bus.busy  = (r_state == S_COUNT);
  assign bus.done  = r_done;

endmodule

// File: tb/tb_decrementer_timer.sv
// Directed bench for decrementer_timer: one-shot instance and auto-reload instance
// share clock and reset; each scenario task checks its own expected values.
module tb_decrementer_timer;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  decrementer_timer_if #(.WIDTH(4)) ifa ();
  decrementer_timer_if #(.WIDTH(4)) ifr ();

  decrementer_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  decrementer_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (ifr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.start = 1'b0; ifa.load_val = 4'd0; ifa.en = 1'b0; ifa.abort = 1'b0;
    ifr.start = 1'b0; ifr.load_val = 4'd0; ifr.en = 1'b0; ifr.abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.start = 1'b1; ifa.load_val = 4'd9; ifa.en = 1'b1;
    ifr.start = 1'b1; ifr.load_val = 4'd9; ifr.en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (ifa.count !== 4'd0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
        $display("FAIL reset_hold_a cyc=%0d count=%0d busy=%b done=%b expected 0/0/0", i, ifa.count, ifa.busy, ifa.done);
        n_fail++;
      end
      n_tests++;
      if (ifr.count !== 4'd0 || ifr.busy !== 1'b0 || ifr.done !== 1'b0) begin
        $display("FAIL reset_hold_r cyc=%0d count=%0d busy=%b done=%b expected 0/0/0", i, ifr.count, ifr.busy, ifr.done);
        n_fail++;
      end
    end
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (ifa.count !== 4'd0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
        $display("FAIL reset_idle cyc=%0d count=%0d busy=%b done=%b expected 0/0/0", i, ifa.count, ifa.busy, ifa.done);
        n_fail++;
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] exp_c [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    ifa.start = 1'b1; ifa.load_val = 4'd5; ifa.en = 1'b1;
    tick();
    ifa.start = 1'b0;
    n_tests++;
    if (ifa.count !== 4'd5 || ifa.busy !== 1'b1 || ifa.done !== 1'b0) begin
      $display("FAIL basic_load count=%0d busy=%b done=%b expected 5/1/0", ifa.count, ifa.busy, ifa.done);
      n_fail++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (ifa.count !== exp_c[i] || ifa.done !== (i == 4) || ifa.busy !== (i != 4)) begin
        $display("FAIL basic_step%0d count=%0d busy=%b done=%b expected %0d/%b/%b",
                 i, ifa.count, ifa.busy, ifa.done, exp_c[i], (i != 4), (i == 4));
        n_fail++;
      end
    end
    tick();
    n_tests++;
    if (ifa.count !== 4'd0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
      $display("FAIL basic_after count=%0d busy=%b done=%b expected 0/0/0", ifa.count, ifa.busy, ifa.done);
      n_fail++;
    end
    idle_inputs();
  endtask

  task automatic test_gaps();
    logic       en_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_c  [5] = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
    ifa.start = 1'b1; ifa.load_val = 4'd3; ifa.en = 1'b0;
    tick();
    ifa.start = 1'b0;
    n_tests++;
    if (ifa.count !== 4'd3 || ifa.busy !== 1'b1) begin
      $display("FAIL gaps_load count=%0d busy=%b expected 3/1", ifa.count, ifa.busy);
      n_fail++;
    end
    for (int i = 0; i < 5; i++) begin
      ifa.en = en_pat[i];
      tick();
      n_tests++;
      if (ifa.count !== exp_c[i] || ifa.done !== (i == 4)) begin
        $display("FAIL gaps_step%0d count=%0d done=%b expected %0d/%b", i, ifa.count, ifa.done, exp_c[i], (i == 4));
        n_fail++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_max();
    int done_at = 0;
    ifa.start = 1'b1; ifa.load_val = 4'hF; ifa.en = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ifa.done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    n_tests++;
    if (done_at !== 15 || ifa.count !== 4'd0) begin
      $display("FAIL max_latency done_at=%0d count=%0d expected 15/0", done_at, ifa.count);
      n_fail++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_zero();
    ifa.start = 1'b1; ifa.load_val = 4'd0; ifa.en = 1'b1;
    tick();
    ifa.start = 1'b0;
    n_tests++;
    if (ifa.done !== 1'b1 || ifa.busy !== 1'b0 || ifa.count !== 4'd0) begin
      $display("FAIL zero_load done=%b busy=%b count=%0d expected 1/0/0", ifa.done, ifa.busy, ifa.count);
      n_fail++;
    end
    tick();
    n_tests++;
    if (ifa.done !== 1'b0 || ifa.busy !== 1'b0) begin
      $display("FAIL zero_after done=%b busy=%b expected 0/0", ifa.done, ifa.busy);
      n_fail++;
    end
    idle_inputs();
  endtask

  task automatic test_restart_abort();
    logic [3:0] exp_c [5] = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2};
    ifa.start = 1'b1; ifa.load_val = 4'd7; ifa.en = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (ifa.count !== exp_c[i] || ifa.done !== 1'b0) begin
        $display("FAIL restart_run%0d count=%0d done=%b expected %0d/0", i, ifa.count, ifa.done, exp_c[i]);
        n_fail++;
      end
    end
    ifa.start = 1'b1; ifa.load_val = 4'd4;
    tick();
    ifa.start = 1'b0;
    n_tests++;
    if (ifa.count !== 4'd4 || ifa.done !== 1'b0 || ifa.busy !== 1'b1) begin
      $display("FAIL restart_load count=%0d done=%b busy=%b expected 4/0/1", ifa.count, ifa.done, ifa.busy);
      n_fail++;
    end
    tick();
    n_tests++;
    if (ifa.count !== 4'd3) begin
      $display("FAIL restart_step count=%0d expected 3", ifa.count);
      n_fail++;
    end
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    n_tests++;
    if (ifa.busy !== 1'b0 || ifa.count !== 4'd3 || ifa.done !== 1'b0) begin
      $display("FAIL abort_hold busy=%b count=%0d done=%b expected 0/3/0", ifa.busy, ifa.count, ifa.done);
      n_fail++;
    end
    tick();
    n_tests++;
    if (ifa.busy !== 1'b0 || ifa.count !== 4'd3) begin
      $display("FAIL abort_idle busy=%b count=%0d expected 0/3", ifa.busy, ifa.count);
      n_fail++;
    end
    ifa.start = 1'b1; ifa.load_val = 4'd2;
    tick();
    ifa.start = 1'b0;
    n_tests++;
    if (ifa.count !== 4'd2 || ifa.busy !== 1'b1) begin
      $display("FAIL post_abort_load count=%0d busy=%b expected 2/1", ifa.count, ifa.busy);
      n_fail++;
    end
    tick();
    tick();
    n_tests++;
    if (ifa.count !== 4'd0 || ifa.done !== 1'b1 || ifa.busy !== 1'b0) begin
      $display("FAIL post_abort_done count=%0d done=%b busy=%b expected 0/1/0", ifa.count, ifa.done, ifa.busy);
      n_fail++;
    end
    idle_inputs();
  endtask

  task automatic test_autoreload();
    logic [3:0] exp_c [9] = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
    ifr.start = 1'b1; ifr.load_val = 4'd3; ifr.en = 1'b1;
    tick();
    ifr.start = 1'b0;
    n_tests++;
    if (ifr.count !== 4'd3 || ifr.busy !== 1'b1 || ifr.done !== 1'b0) begin
      $display("FAIL reload_load count=%0d busy=%b done=%b expected 3/1/0", ifr.count, ifr.busy, ifr.done);
      n_fail++;
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      n_tests++;
      if (ifr.count !== exp_c[i] || ifr.done !== (exp_c[i] == 4'd3) || ifr.busy !== 1'b1) begin
        $display("FAIL reload_step%0d count=%0d done=%b busy=%b expected %0d/%b/1",
                 i, ifr.count, ifr.done, ifr.busy, exp_c[i], (exp_c[i] == 4'd3));
        n_fail++;
      end
    end
    ifr.start = 1'b1; ifr.load_val = 4'd1;
    tick();
    ifr.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (ifr.count !== 4'd1 || ifr.done !== 1'b1 || ifr.busy !== 1'b1) begin
        $display("FAIL reload_one%0d count=%0d done=%b busy=%b expected 1/1/1", i, ifr.count, ifr.done, ifr.busy);
        n_fail++;
      end
    end
    ifr.abort = 1'b1;
    tick();
    n_tests++;
    if (ifr.busy !== 1'b0 || ifr.done !== 1'b0) begin
      $display("FAIL reload_abort busy=%b done=%b expected 0/0", ifr.busy, ifr.done);
      n_fail++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    ifa.start = 1'b1; ifa.load_val = 4'd6; ifa.en = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (ifa.count !== 4'd2) begin
      $display("FAIL rstmid_pre count=%0d expected 2", ifa.count);
      n_fail++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (ifa.count !== 4'd0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
      $display("FAIL rstmid_clear count=%0d busy=%b done=%b expected 0/0/0", ifa.count, ifa.busy, ifa.done);
      n_fail++;
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (ifa.count !== 4'd0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
        $display("FAIL rstmid_en%0d count=%0d busy=%b done=%b expected 0/0/0", i, ifa.count, ifa.busy, ifa.done);
        n_fail++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_gaps();
    test_max();
    test_zero();
    test_restart_abort();
    test_autoreload();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
